// File: rtl/adc_capture_pkg.sv
// Shared state encoding and default parameters for the N-channel ping-pong ADC capture path.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } capState_t;

  localparam int unsigned DEF_NCH    = 4;
  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_AW     = 12;
  localparam int unsigned DEF_SETTLE = 7;
  localparam int unsigned DEF_OVW    = 8;

  // SETTLE is limited to 1..255, so an 8-bit settle timer always suffices.
  localparam int unsigned SETTLE_W   = 8;

endpackage

// File: rtl/adc_chan_writer.sv
// One channel of the capture path: bank fill counter, done flag, registered RAM write port
// and the trigger magnitude compare.
module adc_chan_writer
  import adc_capture_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic          bank,
  input  logic [DW-1:0] sample,
  input  logic          valid,
  input  logic [DW-2:0] threshold,
  output logic          trig,
  output logic          done,
  output logic          ramWe,
  output logic [AW:0]   ramAddr,
  output logic [DW-1:0] ramData
);

  logic [AW-1:0] cntQ, cntD;
  logic          doneQ, doneD;
  logic          accept;
  logic [DW-1:0] negSample;
  logic [DW-2:0] mag;

  always_comb begin
    negSample = -sample;
    if (!sample[DW-1]) begin
      mag = sample[DW-2:0];
    end else if (sample[DW-2:0] == '0) begin
      // The most negative value has no positive twin; clamp to the largest magnitude.
      mag = '1;
    end else begin
      mag = negSample[DW-2:0];
    end
  end

  assign trig   = valid && (mag >= threshold);
  assign accept = enable && valid && !doneQ;
  assign done   = doneQ;

  always_comb begin
    cntD  = cntQ;
    doneD = doneQ;
    if (clear) begin
      cntD  = '0;
      doneD = 1'b0;
    end else if (accept) begin
      cntD = cntQ + 1'b1;
      if (&cntQ) begin
        doneD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ    <= '0;
      doneQ   <= 1'b0;
      ramWe   <= 1'b0;
      ramAddr <= '0;
      ramData <= '0;
    end else begin
      cntQ  <= cntD;
      doneQ <= doneD;
      ramWe <= accept;
      if (accept) begin
        ramAddr <= {bank, cntQ};
        ramData <= sample;
      end
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// N-channel ping-pong ADC capture controller: capture FSM, bank toggle, settle timer for the
// host data-ready flag, and overrun detection.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned NCH    = DEF_NCH,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned OVW    = DEF_OVW
) (
  input  logic                  ADC_I_clk,
  input  logic                  I_rst,
  input  logic [NCH*DW-1:0]     I_chanData,
  input  logic [NCH-1:0]        I_chanValid,
  input  logic                  I_mode,
  input  logic [DW-2:0]         I_threshold,
  input  logic                  I_arm,
  input  logic                  I_dataRead,
  output logic [NCH-1:0]        O_ramWe,
  output logic [NCH*(AW+1)-1:0] O_ramAddr,
  output logic [NCH*DW-1:0]     O_ramData,
  output logic                  O_dataRdy,
  output logic                  O_bankLastFilled,
  output logic                  O_overrun,
  output logic [OVW-1:0]        O_overrunCount,
  output logic [1:0]            O_state
);

  capState_t           stateQ, stateD;
  logic                modeQ;
  logic                fillBankQ, fillBankD;
  logic                lastQ, lastD;
  logic                pendingQ, pendingD;
  logic [SETTLE_W-1:0] settleQ, settleD;
  logic                dataRdyQ, dataRdyD;
  logic                overrunQ, overrunD;
  logic [OVW-1:0]      ovrCntQ, ovrCntD;
  logic                overrunEvt;

  logic [NCH-1:0]      done;
  logic [NCH-1:0]      trig;
  logic                complete;
  logic                trigAny;
  logic                captureEn;

  assign complete = &done;
  assign trigAny  = |trig;
  // Nothing is written in the completion cycle so every channel starts the next bank aligned.
  assign captureEn = !complete &&
                     ((stateQ == ST_CAPTURE) || ((stateQ == ST_ARMED) && trigAny));

  for (genvar k = 0; k < NCH; k++) begin : gChan
    adc_chan_writer #(
      .DW (DW),
      .AW (AW)
    ) uWriter (
      .clk       (ADC_I_clk),
      .rst       (I_rst),
      .enable    (captureEn),
      .clear     (complete),
      .bank      (fillBankQ),
      .sample    (I_chanData[k*DW +: DW]),
      .valid     (I_chanValid[k]),
      .threshold (I_threshold),
      .trig      (trig[k]),
      .done      (done[k]),
      .ramWe     (O_ramWe[k]),
      .ramAddr   (O_ramAddr[k*(AW+1) +: AW+1]),
      .ramData   (O_ramData[k*DW +: DW])
    );
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_IDLE:    if (I_arm) stateD = I_mode ? ST_ARMED : ST_CAPTURE;
      ST_ARMED:   if (trigAny) stateD = ST_CAPTURE;
      ST_CAPTURE: if (modeQ && complete) stateD = ST_HOLD;
      ST_HOLD:    if (I_dataRead) stateD = ST_IDLE;
      default:    stateD = ST_IDLE;
    endcase
  end

  always_comb begin
    fillBankD  = fillBankQ;
    lastD      = lastQ;
    pendingD   = pendingQ;
    settleD    = settleQ;
    dataRdyD   = dataRdyQ;
    overrunD   = overrunQ;
    ovrCntD    = ovrCntQ;
    // pendingQ covers both a running settle timer and an asserted data-ready flag.
    overrunEvt = complete && pendingQ && !I_dataRead;

    if (complete) begin
      lastD     = fillBankQ;
      fillBankD = !fillBankQ;
      pendingD  = 1'b1;
      settleD   = '0;
      dataRdyD  = 1'b0;
    end else if (I_dataRead) begin
      pendingD  = 1'b0;
      settleD   = '0;
      dataRdyD  = 1'b0;
    end else if (pendingQ) begin
      if (settleQ == SETTLE_W'(SETTLE)) begin
        dataRdyD = 1'b1;
      end else begin
        settleD = settleQ + 1'b1;
      end
    end

    if (overrunEvt) begin
      overrunD = 1'b1;
      if (!(&ovrCntQ)) begin
        ovrCntD = ovrCntQ + 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_I_clk) begin
    if (I_rst) begin
      stateQ    <= ST_IDLE;
      modeQ     <= 1'b0;
      fillBankQ <= 1'b0;
      lastQ     <= 1'b0;
      pendingQ  <= 1'b0;
      settleQ   <= '0;
      dataRdyQ  <= 1'b0;
      overrunQ  <= 1'b0;
      ovrCntQ   <= '0;
    end else begin
      stateQ    <= stateD;
      fillBankQ <= fillBankD;
      lastQ     <= lastD;
      pendingQ  <= pendingD;
      settleQ   <= settleD;
      dataRdyQ  <= dataRdyD;
      overrunQ  <= overrunD;
      ovrCntQ   <= ovrCntD;
      if ((stateQ == ST_IDLE) && I_arm) begin
        modeQ <= I_mode;
      end
    end
  end

  assign O_dataRdy        = dataRdyQ;
  assign O_bankLastFilled = lastQ;
  assign O_overrun        = overrunQ;
  assign O_overrunCount   = ovrCntQ;
  assign O_state          = stateQ;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a cycle-level behavioural model and per-cycle compare.
module tb_adc_capture_ctrl;

  localparam int unsigned NCH    = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned SETTLE = 7;
  localparam int unsigned OVW    = 8;
  localparam int          BANK   = 1 << AW;
  localparam int          OVMAX  = (1 << OVW) - 1;

  logic testClk = 1'b0;
  always #5 testClk = ~testClk;

  logic                  rst;
  logic [NCH*DW-1:0]     chanData;
  logic [NCH-1:0]        chanValid;
  logic                  mode;
  logic [DW-2:0]         threshold;
  logic                  arm;
  logic                  dataRead;
  logic [NCH-1:0]        ramWe;
  logic [NCH*(AW+1)-1:0] ramAddr;
  logic [NCH*DW-1:0]     ramData;
  logic                  dataRdy;
  logic                  bankLast;
  logic                  overrun;
  logic [OVW-1:0]        overrunCount;
  logic [1:0]            state;

  adc_capture_ctrl #(
    .NCH    (NCH),
    .DW     (DW),
    .AW     (AW),
    .SETTLE (SETTLE),
    .OVW    (OVW)
  ) dut (
    .ADC_I_clk        (testClk),
    .I_rst            (rst),
    .I_chanData       (chanData),
    .I_chanValid      (chanValid),
    .I_mode           (mode),
    .I_threshold      (threshold),
    .I_arm            (arm),
    .I_dataRead       (dataRead),
    .O_ramWe          (ramWe),
    .O_ramAddr        (ramAddr),
    .O_ramData        (ramData),
    .O_dataRdy        (dataRdy),
    .O_bankLastFilled (bankLast),
    .O_overrun        (overrun),
    .O_overrunCount   (overrunCount),
    .O_state          (state)
  );

  int errors = 0;
  int checks = 0;
  bit cmpEn  = 1'b0;

  // Model: 0 idle, 1 armed, 2 capture, 3 hold; pending tracks an unacknowledged completion.
  int     mState = 0, mMode = 0, mFill = 0, mLast = 0, mPend = 0, mOvr = 0, mOvrCnt = 0;
  int     mCnt[NCH];
  bit     mDone[NCH];
  longint edgeNo = 0, compEdge = 0;
  bit     eWe[NCH];
  int     eAddr[NCH];
  int     eData[NCH];

  function automatic int magOf(logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int expRdy();
    return (mPend != 0 && (edgeNo - compEdge) >= longint'(SETTLE + 1)) ? 1 : 0;
  endfunction

  task automatic modelStep();
    bit complete, trig, accepting;
    edgeNo++;
    if (rst) begin
      mState = 0; mMode = 0; mFill = 0; mLast = 0; mPend = 0; mOvr = 0; mOvrCnt = 0;
      for (int k = 0; k < NCH; k++) begin
        mCnt[k] = 0; mDone[k] = 1'b0; eWe[k] = 1'b0; eAddr[k] = 0; eData[k] = 0;
      end
      return;
    end
    complete = 1'b1;
    trig     = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!mDone[k]) complete = 1'b0;
      if (chanValid[k] && magOf(chanData[k*DW +: DW]) >= int'(threshold)) trig = 1'b1;
    end
    accepting = !complete && (mState == 2 || (mState == 1 && trig));
    for (int k = 0; k < NCH; k++) begin
      eWe[k] = 1'b0;
      if (accepting && chanValid[k] && !mDone[k]) begin
        eWe[k]   = 1'b1;
        eAddr[k] = mFill * BANK + mCnt[k];
        eData[k] = int'(chanData[k*DW +: DW]);
        mCnt[k]++;
        if (mCnt[k] == BANK) mDone[k] = 1'b1;
      end
    end
    if (complete) begin
      mLast = mFill;
      mFill = 1 - mFill;
      for (int k = 0; k < NCH; k++) begin
        mCnt[k] = 0; mDone[k] = 1'b0;
      end
      if (mPend != 0 && !dataRead) begin
        mOvr = 1;
        if (mOvrCnt < OVMAX) mOvrCnt++;
      end
      mPend    = 1;
      compEdge = edgeNo;
    end else if (dataRead) begin
      mPend = 0;
    end
    case (mState)
      0: if (arm) begin mMode = mode ? 1 : 0; mState = mode ? 1 : 2; end
      1: if (trig) mState = 2;
      2: if (mMode != 0 && complete) mState = 3;
      default: if (dataRead) mState = 0;
    endcase
  endtask

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge testClk);
    modelStep();
  end

  initial forever begin
    @(negedge testClk);
    if (cmpEn) begin
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("ramWe[%0d]", k), longint'(ramWe[k]), longint'(eWe[k]));
        check($sformatf("ramAddr[%0d]", k), longint'(ramAddr[k*(AW+1) +: AW+1]),
              longint'(eAddr[k]));
        check($sformatf("ramData[%0d]", k), longint'(ramData[k*DW +: DW]), longint'(eData[k]));
      end
      check("dataRdy", longint'(dataRdy), longint'(expRdy()));
      check("bankLast", longint'(bankLast), longint'(mLast));
      check("overrun", longint'(overrun), longint'(mOvr));
      check("overrunCount", longint'(overrunCount), longint'(mOvrCnt));
      check("state", longint'(state), longint'(mState));
    end
  end

  task automatic step();
    @(posedge testClk);
    #2;
  endtask

  task automatic drive(logic [NCH-1:0] v, int base);
    chanValid = v;
    for (int k = 0; k < NCH; k++) chanData[k*DW +: DW] = 16'(base + k * 256);
  endtask

  task automatic doReset();
    rst = 1'b1; arm = 1'b0; dataRead = 1'b0; chanValid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] v;
    rst = 1'b1; arm = 1'b0; mode = 1'b0; dataRead = 1'b0;
    threshold = '0; chanValid = '0; chanData = '0;
    step();
    cmpEn = 1'b1;
    step();
    check("rst_state", longint'(state), 0);
    check("rst_rdy", longint'(dataRdy), 0);
    check("rst_we", longint'(ramWe), 0);
    check("rst_ovcnt", longint'(overrunCount), 0);
    rst = 1'b0;

    // Continuous mode, all channels every cycle.
    mode = 1'b0; arm = 1'b1; step(); arm = 1'b0;
    check("t1_state", longint'(state), 2);
    for (int s = 1; s <= 34; s++) begin
      drive('1, s);
      dataRead = (s == 26);
      step();
      if (s == 16) check("t1_addr_last", longint'(ramAddr[AW:0]), 'h0F);
      if (s == 17) begin
        check("t1_bank0", longint'(bankLast), 0);
        check("t1_drop", longint'(ramWe), 0);
      end
      if (s == 18) check("t1_addr_next", longint'(ramAddr[AW:0]), 'h10);
      if (s == 24) check("t1_rdy_early", longint'(dataRdy), 0);
      if (s == 25) check("t1_rdy_rise", longint'(dataRdy), 1);
      if (s == 26) check("t1_rdy_ack", longint'(dataRdy), 0);
      if (s == 34) check("t1_bank1", longint'(bankLast), 1);
    end
    dataRead = 1'b0;

    // Skewed: channel 3 on odd cycles only.
    doReset();
    arm = 1'b1; step(); arm = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      v = 4'b0111;
      v[3] = (s % 2 == 1);
      drive(v, s);
      step();
      if (s == 16) check("t2_ch0_last", longint'(ramAddr[AW:0]), 'h0F);
      if (s == 17) check("t2_we_ch3only", longint'(ramWe), 'b1000);
      if (s == 20) check("t2_we_none", longint'(ramWe), 0);
      if (s == 31) check("t2_ch3_last", longint'(ramAddr[3*(AW+1) +: AW+1]), 'h0F);
      if (s == 32) check("t2_complete_drop", longint'(ramWe), 0);
      if (s == 33) check("t2_ch3_next", longint'(ramAddr[3*(AW+1) +: AW+1]), 'h10);
    end

    // Overrun across two unacknowledged completions, then read on a completion cycle.
    doReset();
    arm = 1'b1; step(); arm = 1'b0;
    for (int s = 1; s <= 59; s++) begin
      drive('1, s);
      dataRead = (s == 51);
      step();
      if (s == 33) check("t3_no_ovr", longint'(overrun), 0);
      if (s == 34) begin
        check("t3_ovr", longint'(overrun), 1);
        check("t3_ovcnt", longint'(overrunCount), 1);
        check("t3_bank", longint'(bankLast), 1);
      end
      if (s == 51) begin
        check("t3_read_ovcnt", longint'(overrunCount), 1);
        check("t3_read_rdy", longint'(dataRdy), 0);
      end
      if (s == 58) check("t3_rdy_early", longint'(dataRdy), 0);
      if (s == 59) check("t3_rdy_rerise", longint'(dataRdy), 1);
    end
    dataRead = 1'b0;
    for (int s = 0; s < 17 * 260; s++) begin
      drive('1, s);
      step();
    end
    check("t5_ovcnt_sat", longint'(overrunCount), 'hFF);
    check("t5_ovr_sticky", longint'(overrun), 1);

    // Triggered single-shot, threshold 0x1000 on channel 2.
    doReset();
    threshold = 15'h1000; mode = 1'b1; arm = 1'b1; step(); arm = 1'b0;
    check("t4_armed", longint'(state), 1);
    drive('1, 1);
    for (int k = 0; k < NCH; k++) chanData[k*DW +: DW] = 16'h0001;
    chanData[2*DW +: DW] = 16'h0800;
    step();
    check("t4_no_write", longint'(ramWe), 0);
    chanData[2*DW +: DW] = 16'hF000;
    step();
    check("t4_trig_we", longint'(ramWe), 'hF);
    check("t4_trig_addr", longint'(ramAddr[2*(AW+1) +: AW+1]), 0);
    check("t4_trig_data", longint'(ramData[2*DW +: DW]), 'hF000);
    for (int s = 3; s <= 20; s++) begin
      chanData[2*DW +: DW] = 16'(s);
      step();
      if (s == 17) check("t4_capture", longint'(state), 2);
      if (s == 18) check("t4_hold", longint'(state), 3);
      if (s == 20) check("t4_hold_nowr", longint'(ramWe), 0);
    end
    dataRead = 1'b1; step(); dataRead = 1'b0;
    check("t4_idle", longint'(state), 0);

    // Most negative sample against the largest threshold.
    doReset();
    threshold = 15'h7FFF; mode = 1'b1; arm = 1'b1; step(); arm = 1'b0;
    chanValid = 4'b0010;
    chanData  = '0;
    chanData[1*DW +: DW] = 16'h7FFE;
    step();
    check("t6_below", longint'(state), 1);
    chanData[1*DW +: DW] = 16'h8000;
    step();
    check("t6_trig_state", longint'(state), 2);
    check("t6_trig_we", longint'(ramWe), 'b0010);
    check("t6_trig_data", longint'(ramData[1*DW +: DW]), 'h8000);

    // Reset in the middle of a bank, with arm held during reset.
    doReset();
    mode = 1'b0; threshold = '0; arm = 1'b1; step(); arm = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      drive('1, s + 100);
      step();
    end
    check("t7_addr7", longint'(ramAddr[AW:0]), 7);
    rst = 1'b1; arm = 1'b1; step();
    check("t7_rst_we", longint'(ramWe), 0);
    check("t7_rst_addr", longint'(ramAddr), 0);
    check("t7_rst_data", longint'(ramData), 0);
    check("t7_rst_state", longint'(state), 0);
    rst = 1'b0; arm = 1'b0; chanValid = '0; step();
    check("t7_arm_ignored", longint'(state), 0);
    arm = 1'b1; step(); arm = 1'b0;
    drive('1, 7);
    step();
    check("t7_rearm_we", longint'(ramWe), 'hF);
    check("t7_rearm_addr", longint'(ramAddr[AW:0]), 0);
    chanValid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Parametrised N-channel ADC capture controller. Successor to the fixed four-channel ping-pong capture path.
- Writes per-channel sample streams into double-buffered (ping-pong) sample RAM.
- Aggregates per-channel bank-complete events into one debounced data-ready flag for the Blackfin memory-mapped register block.
- Adds a threshold-triggered single-shot mode and overrun detection. Sits between the ADC deserialisers and the per-channel sample RAMs, in the ADC clock domain.

Parameters:
- NCH, 4, number of ADC channels.
- DW, 16, sample width (two's complement).
- AW, 12, address bits per bank; bank depth = 2^AW samples.
- SETTLE, 7, cycles all channels must remain complete before O_dataRdy asserts (1..255).
- OVW, 8, width of the saturating overrun counter.

Ports:
- ADC_I_clk  in  1  sole clock.
- I_rst  in  1  synchronous, active-high reset.
- I_chanData  in  NCH*DW  channel samples; channel k occupies bits [k*DW +: DW].
- I_chanValid  in  NCH  per-channel sample strobe, one cycle per sample.
- I_mode  in  1  0 = continuous ping-pong, 1 = triggered single-shot; sampled only on I_arm.
- I_threshold  in  DW-1  unsigned magnitude trigger threshold.
- I_arm  in  1  start pulse; ignored unless state = IDLE.
- I_dataRead  in  1  host acknowledge pulse, from memory-mapped control.
- O_ramWe  out  NCH  per-channel RAM write enable.
- O_ramAddr  out  NCH*(AW+1)  per-channel write address; MSB = bank bit.
- O_ramData  out  NCH*DW  per-channel write data.
- O_dataRdy  out  1  a bank is complete on all channels and not yet acknowledged.
- O_bankLastFilled  out  1  bank index most recently completed by all channels.
- O_overrun  out  1  sticky; cleared only by reset.
- O_overrunCount  out  OVW  saturating count of overrun events.
- O_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 HOLD.

Behaviour:
- Reset: every output is 0. Counters, done flags, fill bank and settle timer are 0. State = IDLE.
- RAM write latency is 1. A valid sample accepted at edge t produces O_ramWe/O_ramAddr/O_ramData at t+1, as one registered stage per channel.
- Per-channel write counter cnt[k] (AW bits) and done[k] flag.
  - Sample accepted when: state = CAPTURE, I_chanValid[k] = 1, done[k] = 0.
  - Accepted sample is written at {fillBank, cnt[k]}, then cnt[k] increments.
  - When cnt[k] = 2^AW-1 is written, done[k] sets.
  - Samples on a done channel are dropped (no write).
- Bank complete = &done, registered. On that cycle:
  - O_bankLastFilled <= fillBank.
  - fillBank toggles, all cnt and done clear, settle timer restarts at 0.
  - A valid sample arriving in the completion cycle is dropped on every channel, so channels stay aligned.
- Settle timer counts while the last completion is unacknowledged. O_dataRdy asserts the cycle after the timer reaches SETTLE.
- I_dataRead clears O_dataRdy and the timer on the next edge.
- Overrun: a bank completes while O_dataRdy = 1 or the timer is running, with no I_dataRead in the same cycle.
  - O_overrun sets; O_overrunCount increments, saturating at 2^OVW-1.
  - Capture continues; the new completion overwrites O_bankLastFilled.
- Simultaneous completion and I_dataRead: not an overrun. Timer restarts and O_dataRdy deasserts, then reasserts after SETTLE.
- FSM:
  - IDLE: on I_arm with I_mode = 0, go to CAPTURE. On I_arm with I_mode = 1, go to ARMED.
  - ARMED: trigger = any valid channel with |sample| >= I_threshold. Magnitude of the most negative value saturates to 2^(DW-1)-1. On trigger, go to CAPTURE; that cycle's valid samples on all channels are written at cnt = 0. No writes otherwise.
  - CAPTURE in mode 0: stays in CAPTURE indefinitely.
  - CAPTURE in mode 1: on the first bank complete, go to HOLD.
  - HOLD: no writes. On I_dataRead, go to IDLE. fillBank retains its value.
- Reset mid-capture: returns everything to reset values; partial bank data is abandoned. I_arm during I_rst is ignored.

Decomposition:
- Shared package adc_capture_pkg: state encoding constants (ST_IDLE, ST_ARMED, ST_CAPTURE, ST_HOLD) and default parameter constants.
- One sub-module, adc_chan_writer: per-channel counter, done flag, registered RAM write port and magnitude compare. Instantiated NCH times via generate.
- Top level holds the FSM, bank toggle, settle timer and overrun logic.

Test Plan:
- Continuous mode, AW=4, NCH=4, all channels valid every cycle:
  - Bank 0 fills addresses 0x00-0x0F.
  - O_bankLastFilled = 0.
  - O_dataRdy rises SETTLE+1 cycles after the completion edge.
  - Next writes go to 0x10.
- Skewed channels: channel 3 valid every 2nd cycle, others every cycle.
  - Channels 0-2 stop at cnt = 15 with done set; extra samples are dropped.
  - Bank completes only when channel 3 writes 0x0F.
- No I_dataRead across two completions:
  - O_overrun = 1, O_overrunCount = 1, O_bankLastFilled = 1.
  - I_dataRead on the completion cycle gives count unchanged and O_dataRdy re-rises after SETTLE+1 cycles.
- Triggered mode, threshold 0x1000:
  - Sample sequence 0x0800, 0xF000 (|x| = 0x1000) on channel 2.
  - No writes until 0xF000; 0xF000 is written at address 0.
  - After 16 samples, state = HOLD.
  - I_dataRead returns state to IDLE.
- Edge values: sample 0x8000 with threshold 0x7FFF triggers. Repeated overruns saturate O_overrunCount at 0xFF.
- I_rst asserted mid-bank at cnt = 7: all outputs are 0 the next cycle and state = IDLE. A re-arm restarts at address 0x00.
